alu_acc_seq: RTL and testbench
==============================

# alu_acc_seq

Command sequencer and accumulator that sits directly upstream of the 8-bit combinational ALU. It buffers incoming commands, drives the ALU operand and opcode ports with the accumulator and the command data, and writes the ALU result back into the accumulator. On request it emits the updated accumulator on a valid/ready result port. It turns the stateless ALU into a sequential accumulate-style datapath.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  FIFO can accept; push = cmd_valid_i & cmd_ready_o
- cmd_op_i  in  3  ALU opcode (000 add, 001 sub, 010 shl, 011 shr, 100 and, 101 or, 110 xor, 111 eq)
- cmd_data_i  in  8  operand B, or load value
- cmd_load_i  in  1  1: acc <= cmd_data_i, ALU result ignored
- cmd_emit_i  in  1  1: publish updated acc on result port
- alu_a_o  out  8  to ALU a_i
- alu_b_o  out  8  to ALU b_i
- alu_op_o  out  3  to ALU op_i
- alu_res_i  in  8  from ALU alu_o (combinational, same cycle)
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  8  emitted accumulator value
- acc_o  out  8  current accumulator
- busy_o  out  1  state != IDLE or FIFO non-empty
- cmd_count_o  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Command FIFO holds {op, data, load, emit}, 13 bits per entry. Read/write pointers wrap modulo DEPTH. Occupancy is a separate counter.
- cmd_ready_o = (count < DEPTH) & ~reset. It depends only on registered count, so a pop in the same cycle does not enable a push when full.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Instruction register IR holds the command currently executing.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into IR and go to EXEC; else stay.
  - EXEC (exactly 1 cycle): drive alu_a_o = acc, alu_b_o = IR.data, alu_op_o = IR.op.
    - At the edge, acc <= IR.load ? IR.data : alu_res_i.
    - If IR.emit: res_data_o <= new acc value, res_valid_o <= 1, go to WAIT.
    - Else go to IDLE.
  - WAIT: hold res_valid_o = 1 and res_data_o stable. When res_ready_i = 1, clear res_valid_o at the edge and go to IDLE.
- In IDLE and WAIT, ALU ports are alu_a_o = acc, alu_b_o = 0, alu_op_o = 000 (deterministic, ignored).
- Arithmetic: the ALU result is 8 bits and wraps modulo 256. No carry or overflow is kept. Op 111 writes 0x01 or 0x00 into acc. Shift uses only data[2:0].
- Only one result is ever outstanding. Commands keep entering the FIFO while in WAIT until it is full.

## Timing
- Reset values (held while reset = 1):
  - FIFO empty, pointers and count 0
  - state IDLE, IR 0, acc 0
  - res_valid_o 0, res_data_o 0
  - cmd_ready_o 0, busy_o 0
  - ALU ports {acc = 0, 0, 000}
- cmd_ready_o goes high in the first cycle after reset deasserts.
- Latency: command accepted at edge N into an empty FIFO with state IDLE:
  - IR loaded at edge N+1, EXEC in cycle N+1.
  - acc updated and res_valid_o high after edge N+2.
- Throughput: 2 cycles per non-emit command. Emit commands take 3 cycles minimum: EXEC, then WAIT with res_ready_i = 1.
- Result handshake: transfer at the edge where res_valid_o & res_ready_i. Data must not change while valid and not ready. res_ready_i high while res_valid_o is low has no effect.
- Reset mid-operation (any state) drops the FIFO contents, IR, acc and any pending result. No partial update occurs.
- Commands execute strictly in acceptance order. acc is visible on acc_o one cycle after the EXEC edge.

## Test plan
- Reset: hold reset 3 cycles with cmd_valid_i = 1 -> all outputs at reset values, no push. Release -> cmd_ready_o = 1 next cycle.
- Load+add: push {load, 0x05}, then {000, 0x03, emit} back-to-back, res_ready_i = 1 -> single result 0x08, acc_o = 0x08, busy_o low afterward.
- Wrap: load 0x02, then {001, 0x05, emit} -> res_data_o = 0xFD. Then {010, 0x09, emit} (shift by 1) -> 0xFA.
- Compare: load 0x2A, {111, 0x2A, emit} -> 0x01. Then {000, 0x10, emit} -> 0x11. Then {111, 0x00, emit} -> 0x00.
- Backpressure: res_ready_i = 0, push 6 emit commands.
  - cmd_ready_o drops when count = 4.
  - res_data_o is stable while stalled.
  - After releasing, all 6 results arrive in order and cmd_count_o returns to 0.
- Mid-op reset: assert reset during WAIT with 3 commands queued -> next cycle res_valid_o = 0, cmd_count_o = 0, acc_o = 0. No stale result appears afterward.

Source files
------------

// File: rtl/alu_acc_seq.sv
// alu_acc_seq
// Command sequencer and accumulator placed in front of a stateless 8-bit ALU.
// Commands are buffered in a small FIFO and executed one at a time. During
// execution the accumulator and the command operand are sent to the ALU, and
// the ALU result is written back into the accumulator. A command can also ask
// for the updated accumulator to be published on a valid/ready result port.
// Only one result is outstanding at a time. While a result waits for its
// consumer, new commands keep filling the FIFO.

module alu_acc_seq #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [2:0]                 cmd_op_i,
    input  logic [7:0]                 cmd_data_i,
    input  logic                       cmd_load_i,
    input  logic                       cmd_emit_i,

    output logic [7:0]                 alu_a_o,
    output logic [7:0]                 alu_b_o,
    output logic [2:0]                 alu_op_o,
    input  logic [7:0]                 alu_res_i,

    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [7:0]                 res_data_o,

    output logic [7:0]                 acc_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    // One buffered command: opcode, operand, load flag, emit flag (13 bits)
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic       load;
        logic       emit;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT
    } state_t;

    cmd_t          r_fifo [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    state_t        w_nextState;
    cmd_t          r_ir;
    logic [7:0]    r_acc;
    logic          r_resValid;
    logic [7:0]    r_resData;

    cmd_t          w_inCmd;
    logic [7:0]    w_newAcc;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;

    // Readiness looks only at the registered occupancy, so a pop in the same
    // cycle never opens a slot for a push while the FIFO is full.
    assign w_ready  = (r_count < C_DEPTH) && !reset;
    assign w_push   = cmd_valid_i && w_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
    assign w_inCmd  = {cmd_op_i, cmd_data_i, cmd_load_i, cmd_emit_i};

    // A load takes the operand directly. Otherwise the ALU result is used,
    // and it already wraps at 8 bits.
    assign w_newAcc = r_ir.load ? r_ir.data : alu_res_i;

    // FIFO storage. Entries need no reset because occupancy decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= w_inCmd;
        end
    end

    // FIFO pointers wrap naturally at a power-of-two depth. The occupancy
    // counter stays unchanged when a push and a pop happen together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and ALU operand steering. ALU ports idle at b=0, op=add
    // outside execution so that they are deterministic.
    always_comb begin
        w_nextState = r_state;
        alu_b_o     = '0;
        alu_op_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_b_o     = r_ir.data;
                alu_op_o    = r_ir.op;
                w_nextState = r_ir.emit ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (res_ready_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Instruction register captures the FIFO head as it is popped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= '0;
        end else if (w_pop) begin
            r_ir <= r_fifo[r_rdPtr];
        end
    end

    // Accumulator changes only in the single execute cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (r_state == S_EXEC) begin
            r_acc <= w_newAcc;
        end
    end

    // Result port: capture the new accumulator on an emitting execute cycle
    // and hold it until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resValid <= 1'b0;
            r_resData  <= '0;
        end else if ((r_state == S_EXEC) && r_ir.emit) begin
            r_resValid <= 1'b1;
            r_resData  <= w_newAcc;
        end else if ((r_state == S_WAIT) && res_ready_i) begin
            r_resValid <= 1'b0;
        end
    end

    assign cmd_ready_o = w_ready;
    assign alu_a_o     = r_acc;
    assign res_valid_o = r_resValid;
    assign res_data_o  = r_resData;
    assign acc_o       = r_acc;
    assign busy_o      = (r_state != S_IDLE) || (r_count != '0);
    assign cmd_count_o = r_count;

endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq
// Self-checking bench for alu_acc_seq. It provides the downstream ALU as a
// behavioural function. A command-level model tracks the accumulator and the
// ordered list of results each accepted command should produce.

module tb_alu_acc_seq;

    logic       clk;
    logic       reset;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_op_i;
    logic [7:0] cmd_data_i;
    logic       cmd_load_i;
    logic       cmd_emit_i;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_res_i;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_data_o;
    logic [7:0] acc_o;
    logic       busy_o;
    logic [2:0] cmd_count_o;

    int         nChecks;
    int         nPass;
    int         nFail;
    logic [7:0] expQ[$];
    logic [7:0] modelAcc;
    bit         prevStalled;
    logic [7:0] prevData;
    bit         randomReady;

    alu_acc_seq #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_load_i  (cmd_load_i),
        .cmd_emit_i  (cmd_emit_i),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_res_i   (alu_res_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .acc_o       (acc_o),
        .busy_o      (busy_o),
        .cmd_count_o (cmd_count_o)
    );

    // ALU behaviour written as plain integer arithmetic, reduced modulo 256
    function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia * (1 << (ib % 8));
            3'd3:    r = ia / (1 << (ib % 8));
            3'd4:    r = ia & ib;
            3'd5:    r = ia | ib;
            3'd6:    r = ia ^ ib;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return 8'(r & 255);
    endfunction

    // Downstream combinational ALU fed by the DUT's operand ports
    always_comb begin
        alu_res_i = aluRef(alu_a_o, alu_b_o, alu_op_o);
    end

    initial begin
        clk = 1'b0;
    end

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Guard against a hung handshake anywhere in the sequence
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it and report any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock cycle. Before the edge, account for any command
    // accepted and any result transferred at that edge. Checks run at negedge.
    task automatic applyStimulus();
        bit doPush;
        bit doXfer;
        if (randomReady) begin
            res_ready_i = 1'($urandom_range(0, 1));
        end
        if (prevStalled && (res_valid_o === 1'b1)) begin
            checkOutput("resStable", 32'(res_data_o), 32'(prevData));
        end
        doPush = (cmd_valid_i === 1'b1) && (cmd_ready_o === 1'b1);
        doXfer = (res_valid_o === 1'b1) && (res_ready_i === 1'b1);
        if (doPush) begin
            if (cmd_load_i) begin
                modelAcc = cmd_data_i;
            end else begin
                modelAcc = aluRef(modelAcc, cmd_data_i, cmd_op_i);
            end
            if (cmd_emit_i) begin
                expQ.push_back(modelAcc);
            end
        end
        if (doXfer) begin
            checkOutput("resultPending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                checkOutput("resData", 32'(res_data_o), 32'(expQ.pop_front()));
            end
        end
        prevStalled = (res_valid_o === 1'b1) && (res_ready_i !== 1'b1);
        prevData    = res_data_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one command and hold it until it is accepted
    task automatic pushCmd(input logic [2:0] op, input logic [7:0] data, input logic load, input logic emit);
        bit accepted;
        accepted    = 1'b0;
        cmd_op_i    = op;
        cmd_data_i  = data;
        cmd_load_i  = load;
        cmd_emit_i  = emit;
        cmd_valid_i = 1'b1;
        for (int k = 0; (k < 200) && !accepted; k++) begin
            accepted = (cmd_ready_o === 1'b1);
            applyStimulus();
        end
        cmd_valid_i = 1'b0;
        checkOutput("pushAccepted", 32'(accepted), 32'd1);
    endtask

    // Run until every expected result is consumed and the sequencer is idle
    task automatic drainAll(input string tag);
        randomReady = 1'b0;
        res_ready_i = 1'b1;
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ((busy_o === 1'b0) && (res_valid_o === 1'b0) && (expQ.size() == 0)) begin
                break;
            end
            applyStimulus();
        end
        checkOutput({tag, "Idle"}, 32'({busy_o, res_valid_o}), 32'd0);
        checkOutput({tag, "AllResults"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "Acc"}, 32'(acc_o), 32'(modelAcc));
        checkOutput({tag, "Count"}, 32'(cmd_count_o), 32'd0);
    endtask

    initial begin
        nChecks     = 0;
        nPass       = 0;
        nFail       = 0;
        modelAcc    = 8'h00;
        prevStalled = 1'b0;
        prevData    = 8'h00;
        randomReady = 1'b0;
        reset       = 1'b1;
        res_ready_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = 3'd0;
        cmd_data_i  = 8'h5A;
        cmd_load_i  = 1'b1;
        cmd_emit_i  = 1'b1;

        $display("[TB] reset held with a command offered");
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
        end
        checkOutput("rstReady", 32'(cmd_ready_o), 32'd0);
        checkOutput("rstCount", 32'(cmd_count_o), 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstResValid", 32'(res_valid_o), 32'd0);
        checkOutput("rstResData", 32'(res_data_o), 32'd0);
        checkOutput("rstAcc", 32'(acc_o), 32'd0);
        checkOutput("rstAluPorts", 32'({alu_a_o, alu_b_o, alu_op_o}), 32'd0);
        reset       = 1'b0;
        cmd_valid_i = 1'b0;
        applyStimulus();
        checkOutput("postRstReady", 32'(cmd_ready_o), 32'd1);
        checkOutput("postRstCount", 32'(cmd_count_o), 32'd0);

        $display("[TB] load then add with latency checks");
        pushCmd(3'd0, 8'h05, 1'b1, 1'b0);
        checkOutput("latBusy", 32'(busy_o), 32'd1);
        checkOutput("latAccEarly", 32'(acc_o), 32'd0);
        applyStimulus();
        checkOutput("execAluB", 32'(alu_b_o), 32'h05);
        checkOutput("execAluA", 32'(alu_a_o), 32'h00);
        checkOutput("execAcc", 32'(acc_o), 32'd0);
        applyStimulus();
        checkOutput("loadAcc", 32'(acc_o), 32'h05);
        checkOutput("loadIdle", 32'(busy_o), 32'd0);
        pushCmd(3'd0, 8'h03, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("addAluPorts", 32'({alu_a_o, alu_b_o, alu_op_o}), 32'({8'h05, 8'h03, 3'd0}));
        checkOutput("addValidEarly", 32'(res_valid_o), 32'd0);
        applyStimulus();
        checkOutput("addValid", 32'(res_valid_o), 32'd1);
        checkOutput("addData", 32'(res_data_o), 32'h08);
        checkOutput("addAcc", 32'(acc_o), 32'h08);
        drainAll("add");
        checkOutput("idleAluPorts", 32'({alu_a_o, alu_b_o, alu_op_o}), 32'({8'h08, 8'h00, 3'd0}));

        $display("[TB] wrap-around subtract and shift");
        pushCmd(3'd0, 8'h02, 1'b1, 1'b0);
        pushCmd(3'd1, 8'h05, 1'b0, 1'b1);
        pushCmd(3'd2, 8'h09, 1'b0, 1'b1);
        drainAll("wrap");
        checkOutput("wrapAcc", 32'(acc_o), 32'hFA);

        $display("[TB] compare");
        pushCmd(3'd0, 8'h2A, 1'b1, 1'b0);
        pushCmd(3'd7, 8'h2A, 1'b0, 1'b1);
        pushCmd(3'd0, 8'h10, 1'b0, 1'b1);
        pushCmd(3'd7, 8'h00, 1'b0, 1'b1);
        drainAll("cmp");
        checkOutput("cmpAcc", 32'(acc_o), 32'h00);

        $display("[TB] result backpressure");
        res_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pushCmd(3'(i), 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
        end
        checkOutput("fullCount", 32'(cmd_count_o), 32'd4);
        checkOutput("fullReady", 32'(cmd_ready_o), 32'd0);
        cmd_op_i    = 3'd6;
        cmd_data_i  = 8'hC3;
        cmd_load_i  = 1'b0;
        cmd_emit_i  = 1'b1;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stallReady", 32'(cmd_ready_o), 32'd0);
            checkOutput("stallValid", 32'(res_valid_o), 32'd1);
        end
        res_ready_i = 1'b1;
        pushCmd(3'd6, 8'hC3, 1'b0, 1'b1);
        drainAll("bp");

        $display("[TB] reset while a result waits");
        res_ready_i = 1'b0;
        pushCmd(3'd0, 8'h40, 1'b1, 1'b1);
        pushCmd(3'd0, 8'h01, 1'b0, 1'b1);
        pushCmd(3'd5, 8'h0F, 1'b0, 1'b0);
        pushCmd(3'd6, 8'hFF, 1'b0, 1'b1);
        checkOutput("preRstCount", 32'(cmd_count_o), 32'd3);
        checkOutput("preRstValid", 32'(res_valid_o), 32'd1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("midRstValid", 32'(res_valid_o), 32'd0);
        checkOutput("midRstCount", 32'(cmd_count_o), 32'd0);
        checkOutput("midRstAcc", 32'(acc_o), 32'd0);
        checkOutput("midRstReady", 32'(cmd_ready_o), 32'd0);
        reset       = 1'b0;
        modelAcc    = 8'h00;
        prevStalled = 1'b0;
        expQ.delete();
        res_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
        end
        drainAll("midRst");

        $display("[TB] randomized command stream");
        randomReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus();
            end
            pushCmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        drainAll("rand");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
